// File: rtl/round_k_sequencer.sv
// Round-constant sequencer: streams MD5 / SHA-1 / SHA-256 round constants,
// LANES consecutive constants per beat, under a valid/ready handshake.
module round_k_sequencer #(
  parameter int LANES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            opcode,
  input  logic                  abort,
  input  logic                  k_ready,
  output logic                  k_valid,
  output logic [32*LANES-1:0]   k_val,
  output logic [7:0]            k_round,
  output logic                  k_last,
  output logic                  busy,
  output logic                  err
);

  localparam logic [1:0] MD5            = 2'd0;
  localparam logic [1:0] SHA_1          = 2'd1;
  localparam logic [1:0] SHA_256        = 2'd2;
  localparam logic [1:0] OPCODE_RESERVE = 2'd3;

  localparam logic [31:0] MD5_T [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
  };

  localparam logic [31:0] SHA256_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [1:0] opc_q;
  logic [7:0] last_round_q;

  function automatic logic [31:0] k_of(input logic [1:0] op, input logic [7:0] r);
    logic [31:0] k;
    k = 32'h0;
    case (op)
      MD5:     k = MD5_T[r[5:0]];
      SHA_1: begin
        if      (r < 8'd20) k = 32'h5a827999;
        else if (r < 8'd40) k = 32'h6ed9eba1;
        else if (r < 8'd60) k = 32'h8f1bbcdc;
        else                k = 32'hca62c1d6;
      end
      SHA_256: k = SHA256_K[r[5:0]];
      default: k = 32'h0;
    endcase
    return k;
  endfunction

  function automatic logic [32*LANES-1:0] lanes_of(input logic [1:0] op, input logic [7:0] base);
    logic [32*LANES-1:0] v;
    v = '0;
    for (int i = 0; i < LANES; i++) v[32*i +: 32] = k_of(op, base + 8'(i));
    return v;
  endfunction

  function automatic logic [7:0] rounds_of(input logic [1:0] op);
    return (op == SHA_1) ? 8'd80 : 8'd64;
  endfunction

  // k_val is loaded from the next round index so it lines up with k_round.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      opc_q        <= MD5;
      last_round_q <= 8'd0;
      k_valid      <= 1'b0;
      k_val        <= '0;
      k_round      <= 8'd0;
      k_last       <= 1'b0;
      busy         <= 1'b0;
      err          <= 1'b0;
    end else begin
      err <= 1'b0;
      if (abort) begin
        state   <= IDLE;
        k_valid <= 1'b0;
        k_last  <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (opcode == OPCODE_RESERVE) begin
                err <= 1'b1;
              end else begin
                state        <= RUN;
                opc_q        <= opcode;
                last_round_q <= rounds_of(opcode) - 8'(LANES);
                k_valid      <= 1'b1;
                busy         <= 1'b1;
                k_round      <= 8'd0;
                k_val        <= lanes_of(opcode, 8'd0);
                k_last       <= 1'b0;
              end
            end
          end
          RUN: begin
            if (k_ready) begin
              if (k_last) begin
                state   <= IDLE;
                k_valid <= 1'b0;
                busy    <= 1'b0;
                k_last  <= 1'b0;
              end else begin
                k_round <= k_round + 8'(LANES);
                k_val   <= lanes_of(opc_q, k_round + 8'(LANES));
                k_last  <= ((k_round + 8'(LANES)) == last_round_q);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_k_sequencer.sv
// Bench for round_k_sequencer: LANES=1/2/4 instances share stimulus and are
// compared every cycle against a behavioural model built from the algorithm rules.
module tb_round_k_sequencer;

  localparam logic [1:0] OP_MD5 = 2'd0, OP_SHA1 = 2'd1, OP_SHA256 = 2'd2, OP_RSV = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1, start = 1'b0, abort = 1'b0, k_ready = 1'b1;
  logic [1:0] opcode = OP_MD5;

  logic [31:0]  v1;
  logic [63:0]  v2;
  logic [127:0] v4;
  logic [7:0]   r1, r2, r4;
  logic val1, val2, val4, last1, last2, last4, busy1, busy2, busy4, err1, err2, err4;

  round_k_sequencer #(.LANES(1)) u1 (.clk(clk), .reset(reset), .start(start), .opcode(opcode), .abort(abort),
    .k_ready(k_ready), .k_valid(val1), .k_val(v1), .k_round(r1), .k_last(last1), .busy(busy1), .err(err1));
  round_k_sequencer #(.LANES(2)) u2 (.clk(clk), .reset(reset), .start(start), .opcode(opcode), .abort(abort),
    .k_ready(k_ready), .k_valid(val2), .k_val(v2), .k_round(r2), .k_last(last2), .busy(busy2), .err(err2));
  round_k_sequencer #(.LANES(4)) u4 (.clk(clk), .reset(reset), .start(start), .opcode(opcode), .abort(abort),
    .k_ready(k_ready), .k_valid(val4), .k_val(v4), .k_round(r4), .k_last(last4), .busy(busy4), .err(err4));

  always #5 clk = ~clk;

  logic [127:0] d_val [3];
  logic [7:0]   d_round [3];
  logic         d_valid [3], d_last [3], d_busy [3], d_err [3];
  assign d_val[0] = {96'b0, v1};
  assign d_val[1] = {64'b0, v2};
  assign d_val[2] = v4;
  assign d_round[0] = r1;  assign d_round[1] = r2;  assign d_round[2] = r4;
  assign d_valid[0] = val1; assign d_valid[1] = val2; assign d_valid[2] = val4;
  assign d_last[0] = last1; assign d_last[1] = last2; assign d_last[2] = last4;
  assign d_busy[0] = busy1; assign d_busy[1] = busy2; assign d_busy[2] = busy4;
  assign d_err[0] = err1;   assign d_err[1] = err2;   assign d_err[2] = err4;

  int total = 0, bad = 0;
  int lanes [3] = '{1, 2, 4};
  logic [31:0] md5_t [64];
  logic [31:0] sha_k [64];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference constants from their mathematical definitions.
  function automatic logic [31:0] kref(input int op, input int r);
    if (op == 0) return md5_t[r % 64];
    if (op == 2) return sha_k[r % 64];
    case (r / 20)
      0: return 32'h5a827999;
      1: return 32'h6ed9eba1;
      2: return 32'h8f1bbcdc;
      default: return 32'hca62c1d6;
    endcase
  endfunction

  bit m_init = 0;
  bit m_active [3], m_err [3], m_after_rst [3];
  int m_round [3], m_rounds [3], m_op [3];

  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      if (reset) begin
        m_active[j] = 0; m_err[j] = 0; m_round[j] = 0; m_after_rst[j] = 1;
      end else begin
        m_err[j] = 0; m_after_rst[j] = 0;
        if (abort) m_active[j] = 0;
        else if (!m_active[j]) begin
          if (start && opcode == OP_RSV) m_err[j] = 1;
          else if (start) begin
            m_active[j] = 1; m_round[j] = 0; m_op[j] = int'(opcode);
            m_rounds[j] = (opcode == OP_SHA1) ? 80 : 64;
          end
        end else if (k_ready) begin
          if (m_round[j] + lanes[j] >= m_rounds[j]) m_active[j] = 0;
          else m_round[j] += lanes[j];
        end
      end
    end
    if (reset) m_init = 1;
  end

  function automatic logic [127:0] exp_val(input int j);
    logic [127:0] e = '0;
    for (int i = 0; i < lanes[j]; i++) e[32*i +: 32] = kref(m_op[j], m_round[j] + i);
    return e;
  endfunction

  always @(negedge clk) begin
    if (m_init) begin
      for (int j = 0; j < 3; j++) begin
        chk($sformatf("L%0d k_valid", lanes[j]), d_valid[j], m_active[j]);
        chk($sformatf("L%0d busy", lanes[j]), d_busy[j], m_active[j]);
        chk($sformatf("L%0d err", lanes[j]), d_err[j], m_err[j]);
        if (m_active[j]) begin
          chk($sformatf("L%0d k_round", lanes[j]), d_round[j], 128'(m_round[j]));
          chk($sformatf("L%0d k_last r%0d", lanes[j], m_round[j]), d_last[j],
              m_round[j] == m_rounds[j] - lanes[j]);
          chk($sformatf("L%0d k_val r%0d", lanes[j], m_round[j]), d_val[j], exp_val(j));
        end else begin
          chk($sformatf("L%0d k_last idle", lanes[j]), d_last[j], 1'b0);
          if (m_after_rst[j]) begin
            chk($sformatf("L%0d k_val reset", lanes[j]), d_val[j], 128'h0);
            chk($sformatf("L%0d k_round reset", lanes[j]), d_round[j], 128'h0);
          end
        end
      end
    end
  end

  task automatic wait_round(input int j, input int r);
    int n = 0;
    while (!(d_valid[j] && d_round[j] == 8'(r)) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL wait L%0d round %0d: timed out, k_round=%0d", lanes[j], r, d_round[j]);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((d_busy[0] || d_busy[1] || d_busy[2]) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      total++; bad++;
      $display("FAIL wait idle: timed out, busy=%b%b%b", d_busy[0], d_busy[1], d_busy[2]);
    end
  endtask

  initial begin
    int p, n;
    bit pr;
    real s, c;
    for (int i = 0; i < 64; i++) begin
      s = $sin(real'(i + 1));
      if (s < 0.0) s = -s;
      md5_t[i] = 32'(longint'($floor(s * 4294967296.0)));
    end
    p = 2; n = 0;
    while (n < 64) begin
      pr = 1;
      for (int d = 2; d * d <= p; d++) if (p % d == 0) pr = 0;
      if (pr) begin
        c = $pow(real'(p), 1.0 / 3.0);
        sha_k[n] = 32'(longint'($floor((c - $floor(c)) * 4294967296.0)));
        n++;
      end
      p++;
    end

    repeat (2) @(negedge clk);
    reset = 1'b0;

    // MD5, LANES=1, continuous ready
    opcode = OP_MD5; start = 1'b1; k_ready = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("md5 beat0 k_val", d_val[0], 128'hd76aa478);
    chk("md5 beat0 k_round", d_round[0], 128'h0);
    wait_round(0, 63);
    chk("md5 beat63 k_val", d_val[0], 128'heb86d391);
    chk("md5 beat63 k_last", d_last[0], 1'b1);
    @(negedge clk);
    chk("md5 after last k_valid", d_valid[0], 1'b0);
    chk("md5 after last busy", d_busy[0], 1'b0);
    wait_idle();

    // SHA-1, LANES=4
    opcode = OP_SHA1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_round(2, 16);
    chk("sha1 L4 r16", d_val[2], {4{32'h5a827999}});
    wait_round(2, 20);
    chk("sha1 L4 r20", d_val[2], {4{32'h6ed9eba1}});
    wait_round(2, 76);
    chk("sha1 L4 r76", d_val[2], {4{32'hca62c1d6}});
    chk("sha1 L4 r76 k_last", d_last[2], 1'b1);
    wait_idle();

    // SHA-256, LANES=1, stall at round 5
    opcode = OP_SHA256; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_round(0, 5);
    k_ready = 1'b0;
    chk("sha256 stall k_val c0", d_val[0], 128'h59f111f1);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("sha256 stall k_val c%0d", i), d_val[0], 128'h59f111f1);
      chk($sformatf("sha256 stall k_round c%0d", i), d_round[0], 128'd5);
    end
    k_ready = 1'b1;
    @(negedge clk);
    chk("sha256 release k_val", d_val[0], 128'h923f82a4);
    chk("sha256 release k_round", d_round[0], 128'd6);
    wait_idle();

    // SHA-256, LANES=2, abort at round 10 with ready low, start in same cycle
    opcode = OP_SHA256; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_round(1, 10);
    k_ready = 1'b0;
    @(negedge clk);
    abort = 1'b1; start = 1'b1;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    chk("abort L2 k_valid", d_valid[1], 1'b0);
    chk("abort L2 busy", d_busy[1], 1'b0);
    @(negedge clk);
    chk("abort+start L2 no new seq", d_valid[1], 1'b0);
    k_ready = 1'b1;

    // Reserved opcode, then start while busy
    opcode = OP_RSV; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("rsv err", d_err[0], 1'b1);
    chk("rsv busy", d_busy[0], 1'b0);
    chk("rsv k_valid", d_valid[0], 1'b0);
    @(negedge clk);
    chk("rsv err one cycle", d_err[0], 1'b0);
    opcode = OP_MD5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_round(0, 3);
    opcode = OP_SHA1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("busy start no err", d_err[0], 1'b0);
    chk("busy start k_round", d_round[0], 128'd4);

    // Reset mid-sequence at MD5 round 30
    wait_round(0, 30);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("reset k_valid", d_valid[0], 1'b0);
    chk("reset k_val", d_val[0], 128'h0);
    chk("reset busy", d_busy[0], 1'b0);
    opcode = OP_MD5; start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk("post reset md5 beat0", d_val[0], 128'hd76aa478);
    wait_idle();

    // Randomized traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      start   = ($urandom_range(0, 7) == 0);
      opcode  = 2'($urandom_range(0, 3));
      abort   = ($urandom_range(0, 299) == 0);
      k_ready = ($urandom_range(0, 3) != 0);
      reset   = ($urandom_range(0, 799) == 0);
    end
    @(negedge clk);
    start = 1'b0; abort = 1'b0; reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
